sl_rx_sync: RTL
===============

SL_RX_SYNC -- requirements
Module: sl_rx_sync

Interface
REQ-001 SHALL have parameter MAX_BITS, default 32, meaning data width and mode-3 word length (legal values 32, 64).
REQ-002 SHALL have parameter FILT_LEN, default 3, meaning clk cycles a line level must be stable to be accepted.
REQ-003 SHALL have parameter SKEW_CYC, default 2, meaning clk cycles from the first line fall to the bit/stop decision.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 1024, meaning the mid-word inactivity limit in clk cycles.
REQ-005 SHALL have port clk, input, 1, system clock, with all state on its rising edge.
REQ-006 SHALL have port reset_n, input, 1, reset: asynchronous, active-low.
REQ-007 SHALL have ports sl0 and sl1, input, 1 each, asynchronous serial lines, idle high.
REQ-008 SHALL have port mode, input, 2, word length: 0=8, 1=16, 2=32, 3=MAX_BITS data bits.
REQ-009 SHALL have port out_data, output, MAX_BITS, received word right-aligned, upper bits zero.
REQ-010 SHALL have ports out_valid (output, 1, word available) and out_ready (input, 1, consumer accepts).
REQ-011 SHALL have ports err_parity, err_length, err_timeout and err_overrun, output, 1 each, single-cycle error pulses.
REQ-012 SHALL have port busy, output, 1, high whenever the FSM is not IDLE.

Function
REQ-013 SHALL pass each line through a 2-flop synchroniser and a FILT_LEN stability filter; only filtered levels are decoded.
REQ-014 SHALL use FSM states IDLE, DECIDE, BIT, GAP and WAIT_IDLE.
REQ-015 SHALL move IDLE/GAP->DECIDE on the first filtered fall of either line, then sample both lines after SKEW_CYC cycles.
REQ-016 SHALL decode the DECIDE sample as: sl0 low only = bit 0; sl1 low only = bit 1; both low = stop; both high = glitch, return to the prior state.
REQ-017 SHALL, on a data bit, shift it in LSB-first (first bit lands in out_data[0]), increment the bit count and enter BIT.
REQ-018 SHALL move BIT->GAP when both lines are high.
REQ-019 SHALL latch mode when the first bit of a word is decoded; mode changes mid-word have no effect.
REQ-020 SHALL treat the word as N data bits plus 1 parity bit; the parity bit is not stored; good parity = odd total of ones over N+1 bits.
REQ-021 SHALL saturate the bit count at N+2, beyond which further bits are ignored.
REQ-022 SHALL, on stop: count==N+1 with good parity -> deliver word; count==N+1 with bad parity -> err_parity; count!=N+1 with count>0 -> err_length; count==0 -> no action.
REQ-023 SHALL enter WAIT_IDLE after any stop, then return to IDLE when both lines are high.
REQ-024 SHALL pulse err_timeout if, with count>0, no line fall occurs in GAP, or a line stays low in BIT, for TIMEOUT_CYC cycles; the word is discarded and the FSM enters WAIT_IDLE.
REQ-025 SHALL deliver a word by loading out_data and setting out_valid the cycle after the stop decision.
REQ-026 SHALL hold out_data and out_valid until out_valid and out_ready are both high, which clears out_valid.
REQ-027 SHALL, when a delivery coincides with out_valid high and out_ready low, drop the new word, keep the old one and pulse err_overrun.
REQ-028 SHALL, when a delivery coincides with an out_valid and out_ready handshake, load the new word with out_valid remaining high.
REQ-029 SHALL assert at most one err_* pulse per word.

Reset
REQ-030 SHALL, on reset_n low, immediately clear out_data, out_valid, all err_* outputs, busy, counters and the shift register, and set state to IDLE.
REQ-031 SHALL preset synchroniser and filter flops to high on reset.
REQ-032 SHALL, on reset mid-word, discard the partial word with no error pulse, and decode after release starts at IDLE with a fresh count.

Structure
REQ-033 SHALL place the FSM state enum, mode-to-length function and mode encodings in shared package sl_pkg.
REQ-034 SHALL implement synchroniser plus filter as sub-module sl_line_filter (parameter FILT_LEN), instanced once per line.

Verification
REQ-035 SHALL verify: mode 0, bits 1,0,1,0,0,1,0,1 then parity 1 then stop -> out_valid with out_data=0x000000A5, no errors.
REQ-036 SHALL verify: same word with parity 0 -> err_parity one pulse, out_valid stays 0.
REQ-037 SHALL verify: mode 1, 12 bits then stop -> err_length; next valid 16-bit word 0x1234 is received correctly.
REQ-038 SHALL verify: two good words with out_ready held 0 -> first word retained, err_overrun on the second; then out_ready=1 clears out_valid.
REQ-039 SHALL verify: 5 bits then lines idle for TIMEOUT_CYC+1 cycles -> err_timeout, busy falls; a 1-cycle sl0 glitch produces no bit.
REQ-040 SHALL verify: reset_n pulsed after 20 of 33 mode-2 bits -> all outputs 0, no error; following word 0xDEADBEEF is received correctly.

Source files
------------

// File: rtl/sl_pkg.sv
// Shared definitions for the serial-line receiver.
//   state_t   : receiver FSM states
//   MODE_*    : encodings of the 2-bit mode input
//   mode_len(): number of data bits selected by a mode
package sl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECIDE,
    ST_BIT,
    ST_GAP,
    ST_WAIT_IDLE
  } state_t;

  localparam logic [1:0] MODE_8   = 2'd0;
  localparam logic [1:0] MODE_16  = 2'd1;
  localparam logic [1:0] MODE_32  = 2'd2;
  localparam logic [1:0] MODE_MAX = 2'd3;

  function automatic int unsigned mode_len(input logic [1:0] mode,
                                           input int unsigned max_bits);
    case (mode)
      MODE_8:  return 8;
      MODE_16: return 16;
      MODE_32: return 32;
      default: return max_bits;
    endcase
  endfunction

endpackage

// File: rtl/sl_rx_sync_filter.sv
// Synchroniser plus stability filter for one asynchronous serial line.
//   clk, reset_n : system clock, asynchronous active-low reset
//   line         : raw asynchronous line (idle high)
//   filt         : filtered level; changes only after FILT_LEN equal samples
module sl_line_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic line,
  output logic filt
);

  logic [1:0]          sync;
  logic [FILT_LEN-1:0] hist;

  // Everything presets high so an idle line is not seen as a fall after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync <= '1;
      hist <= '1;
      filt <= 1'b1;
    end else begin
      sync <= {sync[0], line};
      hist <= (hist << 1) | FILT_LEN'(sync[1]);
      if (&hist)
        filt <= 1'b1;
      else if (~|hist)
        filt <= 1'b0;
    end
  end

endmodule

// File: rtl/sl_rx_sync.sv
// Two-line serial receiver: a low on sl0 carries a 0, a low on sl1 carries a 1,
// both low is the stop symbol. Words are N data bits (LSB first) plus an odd
// parity bit, followed by stop.
//   clk, reset_n      : system clock, asynchronous active-low reset
//   sl0, sl1          : asynchronous serial lines, idle high
//   mode              : word length select (8/16/32/MAX_BITS), latched at first bit
//   out_data/valid    : received word, held until out_ready handshake
//   out_ready         : consumer accepts the word
//   err_*             : single-cycle error pulses (parity/length/timeout/overrun)
//   busy              : FSM is not IDLE
module sl_rx_sync
  import sl_pkg::*;
#(
  parameter int MAX_BITS    = 32,
  parameter int FILT_LEN    = 3,
  parameter int SKEW_CYC    = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                sl0,
  input  logic                sl1,
  input  logic [1:0]          mode,
  output logic [MAX_BITS-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                err_parity,
  output logic                err_length,
  output logic                err_timeout,
  output logic                err_overrun,
  output logic                busy
);

  localparam int CW = $clog2(MAX_BITS + 3);
  localparam int IW = $clog2(MAX_BITS);
  localparam int SW = (SKEW_CYC > 1) ? $clog2(SKEW_CYC) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic                f0, f1, f0_q, f1_q;
  logic                fall, rx_bit;
  state_t              state, prior;
  logic [CW-1:0]       cnt, len_q, len_eff;
  logic [MAX_BITS-1:0] shreg;
  logic                par;
  logic [SW-1:0]       skew_cnt;
  logic [TW-1:0]       tmo;

  sl_line_filter #(.FILT_LEN(FILT_LEN)) u_filt0 (
    .clk     (clk),
    .reset_n (reset_n),
    .line    (sl0),
    .filt    (f0)
  );

  sl_line_filter #(.FILT_LEN(FILT_LEN)) u_filt1 (
    .clk     (clk),
    .reset_n (reset_n),
    .line    (sl1),
    .filt    (f1)
  );

  assign fall    = (f0_q & ~f0) | (f1_q & ~f1);
  // Only called when exactly one line is low: sl1 low means a 1.
  assign rx_bit  = ~f1;
  // The first bit of a word uses the live mode; later bits the latched length.
  assign len_eff = (cnt == '0) ? CW'(mode_len(mode, MAX_BITS)) : len_q;
  assign busy    = (state != ST_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      prior       <= ST_IDLE;
      f0_q        <= 1'b1;
      f1_q        <= 1'b1;
      cnt         <= '0;
      len_q       <= '0;
      shreg       <= '0;
      par         <= 1'b0;
      skew_cnt    <= '0;
      tmo         <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      err_parity  <= 1'b0;
      err_length  <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      f0_q        <= f0;
      f1_q        <= f1;
      err_parity  <= 1'b0;
      err_length  <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
      if (out_valid && out_ready)
        out_valid <= 1'b0;

      case (state)
        ST_IDLE, ST_GAP: begin
          if (fall) begin
            prior    <= state;
            state    <= ST_DECIDE;
            skew_cnt <= '0;
          end else if (state == ST_GAP) begin
            if (cnt != '0 && tmo == TW'(TIMEOUT_CYC - 1)) begin
              err_timeout <= 1'b1;
              cnt         <= '0;
              shreg       <= '0;
              par         <= 1'b0;
              state       <= ST_WAIT_IDLE;
            end else begin
              tmo <= tmo + 1'b1;
            end
          end
        end

        ST_DECIDE: begin
          if (skew_cnt != SW'(SKEW_CYC - 1)) begin
            skew_cnt <= skew_cnt + 1'b1;
          end else begin
            tmo <= '0;
            case ({f1, f0})
              2'b11: state <= prior;
              2'b00: begin
                if (cnt == len_q + CW'(1)) begin
                  if (!par)
                    err_parity <= 1'b1;
                  else if (out_valid && !out_ready)
                    err_overrun <= 1'b1;
                  else begin
                    // Overrides the handshake clear above when both coincide.
                    out_data  <= shreg;
                    out_valid <= 1'b1;
                  end
                end else if (cnt != '0) begin
                  err_length <= 1'b1;
                end
                cnt   <= '0;
                shreg <= '0;
                par   <= 1'b0;
                state <= ST_WAIT_IDLE;
              end
              default: begin
                if (cnt == '0)
                  len_q <= len_eff;
                if (cnt < len_eff)
                  shreg[cnt[IW-1:0]] <= rx_bit;
                // Parity covers the N data bits plus the parity bit itself.
                if (cnt <= len_eff)
                  par <= par ^ rx_bit;
                if (cnt < len_eff + CW'(2))
                  cnt <= cnt + 1'b1;
                state <= ST_BIT;
              end
            endcase
          end
        end

        ST_BIT: begin
          if (f0 && f1) begin
            state <= ST_GAP;
            tmo   <= '0;
          end else if (tmo == TW'(TIMEOUT_CYC - 1)) begin
            err_timeout <= 1'b1;
            cnt         <= '0;
            shreg       <= '0;
            par         <= 1'b0;
            state       <= ST_WAIT_IDLE;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end

        ST_WAIT_IDLE: begin
          if (f0 && f1)
            state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
